menu_controller: RTL

MENU_CONTROLLER -- requirements
Module: menu_controller

---
 rtl/menu_controller_pkg.sv | 19 +
 rtl/menu_controller_btn_debounce.sv | 33 +++
 rtl/menu_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/menu_controller_pkg.sv
// Shared constants for the menu controller: screen encoding, option indices and default sizing.
package menu_controller_pkg;

  typedef enum logic [1:0] {
    MENU     = 2'b00,
    PLAY     = 2'b01,
    GAMEOVER = 2'b10
  } screenState_t;

  localparam logic [1:0] OPT_PLAY_1P    = 2'd0;
  localparam logic [1:0] OPT_PLAY_2P    = 2'd1;
  localparam logic [1:0] OPT_HIGH_SCORE = 2'd2;

  localparam int DEFAULT_NUM_OPTIONS  = 3;
  localparam int DEFAULT_BLINK_FRAMES = 30;
  localparam int DEFAULT_HOLD_FRAMES  = 180;
  localparam int DEBOUNCE_TICKS       = 4;

endpackage

// File: rtl/menu_controller_btn_debounce.sv
// Single-button debouncer counted in frame ticks; only built when MENU_DEBOUNCE_EN is defined.
`ifdef MENU_DEBOUNCE_EN
module btn_debounce
  import menu_controller_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic frameTick,
  input  logic btnRaw,
  output logic btnStable
);

  logic [2:0] stableCnt;

  // A new level is accepted only after it has differed from the current one for DEBOUNCE_TICKS frames in a row
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      btnStable <= 1'b0;
      stableCnt <= '0;
    end else if (btnRaw == btnStable) begin
      stableCnt <= '0;
    end else if (frameTick) begin
      if (stableCnt == 3'(DEBOUNCE_TICKS - 1)) begin
        btnStable <= btnRaw;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + 3'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/menu_controller.sv
// Title/game-over screen sequencer with option selection, highlight blink and high-score tracking.
// Define MENU_DEBOUNCE_EN to route each button through a frame-tick debouncer.
module menu_controller
  import menu_controller_pkg::*;
#(
  parameter int NUM_OPTIONS  = DEFAULT_NUM_OPTIONS,
  parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES,
  parameter int HOLD_FRAMES  = DEFAULT_HOLD_FRAMES
)(
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_select,
  input  logic        game_over,
  input  logic [31:0] score,
  output logic [1:0]  screen,
  output logic [1:0]  option_sel,
  output logic        highlight_on,
  output logic        start_1p,
  output logic        start_2p,
  output logic [31:0] high_score
);

  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);

  screenState_t state, stateNext;
  logic [1:0]   optionNext;
  logic         start1pNext, start2pNext;
  logic         upLvl, downLvl, selLvl;
  logic         upPrev, downPrev, selPrev;
  logic         upEdge, downEdge, selEdge;
  logic [BLINK_W-1:0] blinkCnt;
  logic [HOLD_W-1:0]  holdCnt;

`ifdef MENU_DEBOUNCE_EN
  btn_debounce upDeb   (.clock(clock), .resetn(resetn), .frameTick(frame_tick), .btnRaw(btn_up),     .btnStable(upLvl));
  btn_debounce downDeb (.clock(clock), .resetn(resetn), .frameTick(frame_tick), .btnRaw(btn_down),   .btnStable(downLvl));
  btn_debounce selDeb  (.clock(clock), .resetn(resetn), .frameTick(frame_tick), .btnRaw(btn_select), .btnStable(selLvl));
`else
  assign upLvl   = btn_up;
  assign downLvl = btn_down;
  assign selLvl  = btn_select;
`endif

  assign upEdge   = upLvl & ~upPrev;
  assign downEdge = downLvl & ~downPrev;
  assign selEdge  = selLvl & ~selPrev;
  assign screen   = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      upPrev   <= 1'b0;
      downPrev <= 1'b0;
      selPrev  <= 1'b0;
    end else begin
      upPrev   <= upLvl;
      downPrev <= downLvl;
      selPrev  <= selLvl;
    end
  end

  // Select beats up/down; opposing up and down edges cancel each other
  always_comb begin
    stateNext   = state;
    optionNext  = option_sel;
    start1pNext = 1'b0;
    start2pNext = 1'b0;
    case (state)
      MENU: begin
        if (selEdge) begin
          if (option_sel == OPT_PLAY_1P) begin
            stateNext   = PLAY;
            start1pNext = 1'b1;
          end else if (option_sel == OPT_PLAY_2P) begin
            stateNext   = PLAY;
            start2pNext = 1'b1;
          end
        end else if (upEdge && !downEdge) begin
          optionNext = (option_sel == 2'd0) ? 2'(NUM_OPTIONS - 1) : option_sel - 2'd1;
        end else if (downEdge && !upEdge) begin
          optionNext = (option_sel == 2'(NUM_OPTIONS - 1)) ? 2'd0 : option_sel + 2'd1;
        end
      end
      PLAY: begin
        if (game_over) stateNext = GAMEOVER;
      end
      GAMEOVER: begin
        if (selEdge || (frame_tick && holdCnt == HOLD_W'(HOLD_FRAMES - 1))) begin
          stateNext  = MENU;
          optionNext = OPT_PLAY_1P;
        end
      end
      default: stateNext = MENU;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= MENU;
      option_sel <= OPT_PLAY_1P;
      start_1p   <= 1'b0;
      start_2p   <= 1'b0;
    end else begin
      state      <= stateNext;
      option_sel <= optionNext;
      start_1p   <= start1pNext;
      start_2p   <= start2pNext;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      high_score <= '0;
    end else if (state == PLAY && game_over && score > high_score) begin
      high_score <= score;
    end
  end

  // Counters sit cleared outside their own screen so each visit starts fresh
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      holdCnt <= '0;
    end else if (state != GAMEOVER) begin
      holdCnt <= '0;
    end else if (frame_tick) begin
      holdCnt <= holdCnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blinkCnt     <= '0;
      highlight_on <= 1'b1;
    end else if (state != MENU) begin
      blinkCnt     <= '0;
      highlight_on <= 1'b1;
    end else if (frame_tick) begin
      if (blinkCnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blinkCnt     <= '0;
        highlight_on <= ~highlight_on;
      end else begin
        blinkCnt <= blinkCnt + BLINK_W'(1);
      end
    end
  end

endmodule
